perf_monitor: RTL and testbench

PERF_MONITOR -- requirements
Module: perf_monitor

---
 rtl/perf_monitor.sv | 161 ++++++++++++++++
 tb/tb_perf_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// perf_monitor: counts cycles, retired instructions and stalled cycles of a
// CPU pipeline until the program parks in its halt loop or a cycle budget runs
// out.
//
// Parameters:
//   CNT_W        width of every counter output
//   HALT_INSTR   fetch-stage instruction word that marks the halt loop
//   HALT_CONFIRM consecutive halt-condition edges required (1..15)
//   MAX_CYCLES   cycle budget before timeout
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   fetch_instr   instruction leaving the fetch stage
//   decode_instr  instruction held in the decode stage
//   retire_valid  one instruction retires this cycle
//   stall         pipeline stalled this cycle
//   cycle_count   elapsed cycles (halt-time snapshot once halted)
//   instr_count   retired instructions
//   stall_count   stalled cycles
//   halted        halt loop confirmed (terminal)
//   timeout       cycle budget exhausted without halt (terminal)
//   done          one-cycle pulse on entry to either terminal state
module perf_monitor #(
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] HALT_INSTR   = 32'h0000006F,
  parameter int unsigned HALT_CONFIRM = 2,
  parameter int unsigned MAX_CYCLES   = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_instr,
  input  logic [31:0]      decode_instr,
  input  logic             retire_valid,
  input  logic             stall,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count,
  output logic             halted,
  output logic             timeout,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_CONFIRM,
    ST_HALTED,
    ST_TIMEOUT
  } state_t;

  localparam logic [CNT_W-1:0] LP_ONES   = '1;
  localparam logic [63:0]      LP_LIMIT  = 64'(MAX_CYCLES) - 64'd1;
  localparam logic             LP_DIRECT = (HALT_CONFIRM <= 32'd1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_instr;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_snap;
  logic [3:0]       r_conf;
  logic             r_halted;
  logic             r_timeout;
  logic             r_done;

  logic w_hc;
  logic w_active;
  logic w_at_limit;
  logic w_conf_done;
  logic w_terminal_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LP_ONES) ? v : v + 1'b1;
  endfunction

  assign w_hc        = (fetch_instr == HALT_INSTR) && (decode_instr == 32'h0);
  assign w_active    = (r_state == ST_RUN) || (r_state == ST_CONFIRM);
  assign w_at_limit  = (64'(r_cyc) == LP_LIMIT);
  // r_conf already counts the edges seen; this edge makes it r_conf+1
  assign w_conf_done = ((32'(r_conf) + 32'd1) >= HALT_CONFIRM);
  assign w_terminal_next = (w_next == ST_HALTED) || (w_next == ST_TIMEOUT);

  // Halt beats timeout when both land on the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_hc && LP_DIRECT) begin
          w_next = ST_HALTED;
        end else if (w_at_limit) begin
          w_next = ST_TIMEOUT;
        end else if (w_hc) begin
          w_next = ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        if (w_hc && w_conf_done) begin
          w_next = ST_HALTED;
        end else if (w_at_limit) begin
          w_next = ST_TIMEOUT;
        end else if (!w_hc) begin
          w_next = ST_RUN;
        end
      end
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc     <= '0;
      r_instr   <= '0;
      r_stall   <= '0;
      r_snap    <= '0;
      r_conf    <= '0;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_halted  <= (w_next == ST_HALTED);
      r_timeout <= (w_next == ST_TIMEOUT);
      r_done    <= w_active && w_terminal_next;
      if (w_active) begin
        r_cyc <= sat_inc(r_cyc);
        if (retire_valid) begin
          r_instr <= sat_inc(r_instr);
        end
        if (stall) begin
          r_stall <= sat_inc(r_stall);
        end
      end
      if (r_state == ST_RUN && w_hc) begin
        r_snap <= r_cyc;
        r_conf <= 4'd1;
      end else if (r_state == ST_CONFIRM) begin
        if (!w_hc) begin
          r_snap <= '0;
          r_conf <= '0;
        end else if (!w_conf_done) begin
          r_conf <= r_conf + 4'd1;
        end
      end
    end
  end

  assign cycle_count = (r_state == ST_HALTED) ? r_snap : r_cyc;
  assign instr_count = r_instr;
  assign stall_count = r_stall;
  assign halted      = r_halted;
  assign timeout     = r_timeout;
  assign done        = r_done;

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor. Five instances share one stimulus
// stream: default, short budget (MAX_CYCLES=20), narrow counters (CNT_W=4),
// single-edge confirm (HALT_CONFIRM=1) and a budget that expires on the very
// edge the halt is confirmed (MAX_CYCLES=102).
module tb_perf_monitor;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_instr;
  logic [31:0] decode_instr;
  logic        retire_valid;
  logic        stall;

  logic [31:0] m_cyc, m_ins, m_stc;
  logic        m_hlt, m_tmo, m_dn;
  logic [31:0] t_cyc, t_ins, t_stc;
  logic        t_hlt, t_tmo, t_dn;
  logic [3:0]  w_cyc, w_ins, w_stc;
  logic        w_hlt, w_tmo, w_dn;
  logic [31:0] h_cyc, h_ins, h_stc;
  logic        h_hlt, h_tmo, h_dn;
  logic [31:0] p_cyc, p_ins, p_stc;
  logic        p_hlt, p_tmo, p_dn;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  perf_monitor dut (
    .clk(clk), .rst(rst), .fetch_instr(fetch_instr), .decode_instr(decode_instr),
    .retire_valid(retire_valid), .stall(stall),
    .cycle_count(m_cyc), .instr_count(m_ins), .stall_count(m_stc),
    .halted(m_hlt), .timeout(m_tmo), .done(m_dn));

  perf_monitor #(.MAX_CYCLES(20)) u_tmo (
    .clk(clk), .rst(rst), .fetch_instr(fetch_instr), .decode_instr(decode_instr),
    .retire_valid(retire_valid), .stall(stall),
    .cycle_count(t_cyc), .instr_count(t_ins), .stall_count(t_stc),
    .halted(t_hlt), .timeout(t_tmo), .done(t_dn));

  perf_monitor #(.CNT_W(4)) u_w4 (
    .clk(clk), .rst(rst), .fetch_instr(fetch_instr), .decode_instr(decode_instr),
    .retire_valid(retire_valid), .stall(stall),
    .cycle_count(w_cyc), .instr_count(w_ins), .stall_count(w_stc),
    .halted(w_hlt), .timeout(w_tmo), .done(w_dn));

  perf_monitor #(.HALT_CONFIRM(1)) u_h1 (
    .clk(clk), .rst(rst), .fetch_instr(fetch_instr), .decode_instr(decode_instr),
    .retire_valid(retire_valid), .stall(stall),
    .cycle_count(h_cyc), .instr_count(h_ins), .stall_count(h_stc),
    .halted(h_hlt), .timeout(h_tmo), .done(h_dn));

  perf_monitor #(.MAX_CYCLES(102)) u_pri (
    .clk(clk), .rst(rst), .fetch_instr(fetch_instr), .decode_instr(decode_instr),
    .retire_valid(retire_valid), .stall(stall),
    .cycle_count(p_cyc), .instr_count(p_ins), .stall_count(p_stc),
    .halted(p_hlt), .timeout(p_tmo), .done(p_dn));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic [31:0] f;
    logic [31:0] d;
    logic        ret;
    logic        stl;
    logic [31:0] cyc;
    logic [31:0] ins;
    logic [31:0] stc;
    logic        hlt;
    logic        tmo;
    logic        dn;
    logic [31:0] h1_cyc;
    logic        h1_hlt;
    logic        h1_dn;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] f, input logic [31:0] d,
                       input logic ret, input logic stl);
    fetch_instr  = f;
    decode_instr = d;
    retire_valid = ret;
    stall        = stl;
  endtask

  // Called #1 after an edge: reset pulses between edges, next edge is cycle 0.
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  localparam logic [31:0] HI = 32'h0000006F;
  localparam logic [31:0] NP = 32'h00000013;

  initial begin
    //          n   fetch decode ret stl  cyc  ins  stc h t d  h1cyc h1h h1d
    vt[0] = '{30, NP, NP,    1'b1, 1'b0, 30,  30,  0, 0, 0, 0, 30,  0, 0};
    vt[1] = '{7,  HI, NP,    1'b0, 1'b1, 37,  30,  7, 0, 0, 0, 37,  0, 0};
    vt[2] = '{63, NP, 32'h0, 1'b0, 1'b0, 100, 30,  7, 0, 0, 0, 100, 0, 0};
    vt[3] = '{1,  HI, 32'h0, 1'b0, 1'b0, 101, 30,  7, 0, 0, 0, 100, 1, 1};
    vt[4] = '{1,  HI, 32'h0, 1'b0, 1'b0, 100, 30,  7, 1, 0, 1, 100, 1, 0};
    vt[5] = '{1,  HI, 32'h0, 1'b1, 1'b1, 100, 30,  7, 1, 0, 0, 100, 1, 0};
    vt[6] = '{20, NP, NP,    1'b1, 1'b1, 100, 30,  7, 1, 0, 0, 100, 1, 0};

    rst = 1'b1;
    drive(NP, NP, 1'b0, 1'b0);
    step(2);
    chk("rst_cyc", m_cyc, 0);
    chk("rst_ins", m_ins, 0);
    chk("rst_stc", m_stc, 0);
    chk("rst_flags", {m_hlt, m_tmo, m_dn}, 0);
    rst = 1'b0;

    // Halt run: counts, halt after two confirm edges, frozen afterwards.
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].f, vt[i].d, vt[i].ret, vt[i].stl);
      step(vt[i].n);
      chk($sformatf("v%0d_cyc", i), m_cyc, vt[i].cyc);
      chk($sformatf("v%0d_ins", i), m_ins, vt[i].ins);
      chk($sformatf("v%0d_stc", i), m_stc, vt[i].stc);
      chk($sformatf("v%0d_hlt", i), m_hlt, vt[i].hlt);
      chk($sformatf("v%0d_tmo", i), m_tmo, vt[i].tmo);
      chk($sformatf("v%0d_done", i), m_dn, vt[i].dn);
      chk($sformatf("v%0d_h1_cyc", i), h_cyc, vt[i].h1_cyc);
      chk($sformatf("v%0d_h1_hlt", i), h_hlt, vt[i].h1_hlt);
      chk($sformatf("v%0d_h1_done", i), h_dn, vt[i].h1_dn);
    end
    chk("pri_hlt", p_hlt, 1);
    chk("pri_tmo", p_tmo, 0);
    chk("pri_cyc", p_cyc, 100);
    chk("tmo_after_run", {t_hlt, t_tmo}, 2'b01);
    chk("tmo_cyc_run", t_cyc, 20);
    chk("tmo_ins_run", t_ins, 20);
    chk("w4_cyc_run", w_cyc, 15);
    chk("w4_ins_run", w_ins, 15);
    chk("w4_stc_run", w_stc, 7);

    // Asynchronous reset between edges while halted.
    rst = 1'b1;
    #1;
    chk("arst_cyc", m_cyc, 0);
    chk("arst_ins", m_ins, 0);
    chk("arst_stc", m_stc, 0);
    chk("arst_flags", {m_hlt, m_tmo, m_dn}, 0);
    chk("arst_tmo_flag", t_tmo, 0);
    rst = 1'b0;

    // Timeout at the budget boundary, and saturation of narrow counters.
    drive(NP, NP, 1'b1, 1'b0);
    step(1);
    chk("first_edge_cyc", m_cyc, 1);
    step(18);
    chk("tmo_pre_flag", t_tmo, 0);
    chk("tmo_pre_cyc", t_cyc, 19);
    step(1);
    chk("tmo_flag", t_tmo, 1);
    chk("tmo_hlt", t_hlt, 0);
    chk("tmo_done", t_dn, 1);
    chk("tmo_cyc", t_cyc, 20);
    step(1);
    chk("tmo_done_drop", t_dn, 0);
    step(19);
    chk("tmo_frozen_cyc", t_cyc, 20);
    chk("tmo_frozen_ins", t_ins, 20);
    chk("tmo_done_stays", t_dn, 0);
    chk("w4_sat_ins", w_ins, 15);
    chk("w4_sat_cyc", w_cyc, 15);
    chk("main_no_tmo", m_tmo, 0);

    // Confirm aborted by a single non-halt edge, then a real halt.
    pulse_reset();
    drive(NP, NP, 1'b0, 1'b0);
    step(50);
    drive(HI, 32'h0, 1'b0, 1'b0);
    step(1);
    chk("abort_confirm_hlt", m_hlt, 0);
    chk("abort_confirm_cyc", m_cyc, 51);
    chk("abort_h1_hlt", h_hlt, 1);
    chk("abort_h1_cyc", h_cyc, 50);
    drive(NP, NP, 1'b0, 1'b0);
    step(1);
    chk("abort_back_run", m_hlt, 0);
    step(28);
    drive(HI, 32'h0, 1'b0, 1'b0);
    step(1);
    chk("abort_second_hc", m_hlt, 0);
    step(1);
    chk("abort_hlt", m_hlt, 1);
    chk("abort_cyc", m_cyc, 80);
    chk("abort_done", m_dn, 1);
    step(1);
    chk("abort_done_drop", m_dn, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
